// File: rtl/req_pending_arbiter_pkg.sv
// Shared constants and types for the request-pending arbiter.
// The arbiter is fixed at 8 lines because its index comes from encoder8to3.
package req_pending_arbiter_pkg;

    localparam int N_REQ = 8;
    localparam int IDX_W = $clog2(N_REQ);

    typedef logic [IDX_W-1:0] idx_t;
    typedef logic [N_REQ-1:0] req_vec_t;

    function automatic req_vec_t idx_onehot(input idx_t idx);
        req_vec_t v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/req_pending_arbiter_if.sv
// Request/grant bundle between raw request sources, the arbiter, and the consumer.
// The slave modport is the arbiter side; master is the environment driving it.
interface req_pending_arbiter_if
    import req_pending_arbiter_pkg::*;
();

    req_vec_t req_i;
    req_vec_t mask_i;
    req_vec_t ovf_clr_i;
    logic     out_ready_i;
    logic     out_valid_o;
    idx_t     out_idx_o;
    req_vec_t pending_o;
    req_vec_t ovf_o;

    modport slave (
        input  req_i, mask_i, ovf_clr_i, out_ready_i,
        output out_valid_o, out_idx_o, pending_o, ovf_o
    );

    modport master (
        output req_i, mask_i, ovf_clr_i, out_ready_i,
        input  out_valid_o, out_idx_o, pending_o, ovf_o
    );

endinterface

// File: rtl/encoder8to3.sv
// 8-to-3 priority encoder: index of the highest set bit, 0 when no bit is set.
module encoder8to3 (
    input  logic [7:0] d_i,
    output logic [2:0] y_o
);

    // NOTE: y_o gets a default before the loop so every path assigns it and no latch is inferred.
    always_comb begin
        y_o = '0;
        for (int i = 0; i < 8; i++) begin
            if (d_i[i]) y_o = 3'(i);
        end
    end

endmodule

// File: rtl/req_pending_arbiter.sv
// Synchronises 8 asynchronous request lines into a pending register and grants them
// one at a time, highest index first, through a registered valid/ready output.
module req_pending_arbiter
    import req_pending_arbiter_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter bit EDGE_MODE   = 1'b1
) (
    input logic               clk,
    input logic               rst_n,
    req_pending_arbiter_if.slave bus
);

    logic [SYNC_STAGES-1:0][N_REQ-1:0] sync_q, sync_d;
    req_vec_t s_prev_q;
    req_vec_t pending_q, pending_d;
    req_vec_t ovf_q, ovf_d;
    logic     out_valid_q, out_valid_d;
    idx_t     out_idx_q, out_idx_d;

    req_vec_t sync_last;
    req_vec_t ev;
    req_vec_t clr;
    req_vec_t elig;
    logic     accept;
    logic     load;
    idx_t     enc_idx;

    encoder8to3 u_enc (
        .d_i (elig),
        .y_o (enc_idx)
    );

    assign sync_d    = {sync_q[SYNC_STAGES-2:0], bus.req_i};
    assign sync_last = sync_q[SYNC_STAGES-1];
    assign ev        = EDGE_MODE ? (sync_last & ~s_prev_q) : sync_last;

    assign accept = out_valid_q & bus.out_ready_i;
    assign clr    = accept ? idx_onehot(out_idx_q) : '0;
    // The line being granted this cycle must not be offered again on the same load.
    assign elig   = pending_q & ~bus.mask_i & ~clr;
    assign load   = ~out_valid_q | accept;

    always_comb begin
        pending_d   = (pending_q & ~clr) | ev;
        ovf_d       = (ovf_q & ~bus.ovf_clr_i) | (ev & pending_q & ~clr);
        out_valid_d = out_valid_q;
        out_idx_d   = out_idx_q;
        if (load) begin
            out_valid_d = |elig;
            if (|elig) out_idx_d = enc_idx;
        end
    end

    // NOTE: every flop, including the synchroniser chain, is cleared by the async reset;
    // sequential state is written only with non-blocking assignments.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q      <= '0;
            s_prev_q    <= '0;
            pending_q   <= '0;
            ovf_q       <= '0;
            out_valid_q <= 1'b0;
            out_idx_q   <= '0;
        end else begin
            sync_q      <= sync_d;
            s_prev_q    <= sync_last;
            pending_q   <= pending_d;
            ovf_q       <= ovf_d;
            out_valid_q <= out_valid_d;
            out_idx_q   <= out_idx_d;
        end
    end

    assign bus.out_valid_o = out_valid_q;
    assign bus.out_idx_o   = out_idx_q;
    assign bus.pending_o   = pending_q;
    assign bus.ovf_o       = ovf_q;

endmodule

// File: tb/tb_req_pending_arbiter.sv
// Directed bench for req_pending_arbiter: latency, priority, stall, overflow, mask, reset.
module tb_req_pending_arbiter;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    req_pending_arbiter_if bus_if ();

    req_pending_arbiter #(
        .SYNC_STAGES (2),
        .EDGE_MODE   (1'b1)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) @(negedge clk);
    endtask

    task automatic check_out(input string tag, input logic v, input logic [2:0] idx);
        check({tag, " valid"}, {7'd0, bus_if.out_valid_o}, {7'd0, v});
        if (v) check({tag, " idx"}, {5'd0, bus_if.out_idx_o}, {5'd0, idx});
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n                = 1'b0;
        bus_if.req_i         = '0;
        bus_if.mask_i        = '0;
        bus_if.ovf_clr_i     = '0;
        bus_if.out_ready_i   = 1'b0;

        // Reset state
        tick(2);
        check("rst valid", {7'd0, bus_if.out_valid_o}, 8'h00);
        check("rst idx", {5'd0, bus_if.out_idx_o}, 8'h00);
        check("rst pending", bus_if.pending_o, 8'h00);
        check("rst ovf", bus_if.ovf_o, 8'h00);
        rst_n = 1'b1;
        tick(2);

        // Latency: single pulse on line 4
        bus_if.out_ready_i = 1'b1;
        bus_if.req_i = 8'h10; tick;          // E0
        bus_if.req_i = 8'h00; tick;          // E1
        tick;                                // E2
        check("lat pending E2", bus_if.pending_o, 8'h10);
        check_out("lat E2", 1'b0, 3'd0);
        tick;                                // E3
        check_out("lat E3", 1'b1, 3'd4);
        tick;                                // E4
        check("lat pending E4", bus_if.pending_o, 8'h00);
        check_out("lat E4", 1'b0, 3'd0);
        tick(2);

        // Priority + back-to-back on 0x85
        bus_if.req_i = 8'h85; tick(2);       // E1
        tick;                                // E2
        check("b2b pending", bus_if.pending_o, 8'h85);
        tick; check_out("b2b 1st", 1'b1, 3'd7);
        tick; check_out("b2b 2nd", 1'b1, 3'd2);
        tick; check_out("b2b 3rd", 1'b1, 3'd0);
        tick; check_out("b2b end", 1'b0, 3'd0);
        check("b2b pending end", bus_if.pending_o, 8'h00);
        bus_if.req_i = 8'h00; tick(3);

        // Stall stability: idx 1 held while line 6 arrives
        bus_if.out_ready_i = 1'b0;
        bus_if.req_i = 8'h02; tick;
        bus_if.req_i = 8'h00; tick(2);
        tick; check_out("stall first", 1'b1, 3'd1);
        bus_if.req_i = 8'h40; tick;
        bus_if.req_i = 8'h00; tick(2);
        check("stall pending", bus_if.pending_o, 8'h42);
        check_out("stall held", 1'b1, 3'd1);
        tick; check_out("stall held2", 1'b1, 3'd1);
        bus_if.out_ready_i = 1'b1;
        tick; check_out("stall next", 1'b1, 3'd6);
        tick; check_out("stall done", 1'b0, 3'd0);
        check("stall pending end", bus_if.pending_o, 8'h00);
        bus_if.out_ready_i = 1'b0;
        tick(2);

        // Overflow on line 3, then set-wins on accept
        bus_if.req_i = 8'h08; tick;
        bus_if.req_i = 8'h00; tick(3);
        check_out("ovf first", 1'b1, 3'd3);
        check("ovf none yet", bus_if.ovf_o, 8'h00);
        tick;
        bus_if.req_i = 8'h08; tick;          // E0
        bus_if.req_i = 8'h00; tick(2);       // E2
        check("ovf set", bus_if.ovf_o, 8'h08);
        check("ovf pending", bus_if.pending_o, 8'h08);
        tick;
        check("ovf sticky", bus_if.ovf_o, 8'h08);
        bus_if.ovf_clr_i = 8'h08; tick;
        bus_if.ovf_clr_i = 8'h00;
        check("ovf cleared", bus_if.ovf_o, 8'h00);
        tick;
        bus_if.req_i = 8'h08; tick;          // E0
        bus_if.req_i = 8'h00; tick;          // E1
        bus_if.out_ready_i = 1'b1; tick;     // E2: accept and new event together
        check("setwin pending", bus_if.pending_o, 8'h08);
        check("setwin ovf", bus_if.ovf_o, 8'h00);
        check_out("setwin gap", 1'b0, 3'd0);
        tick; check_out("setwin regrant", 1'b1, 3'd3);
        tick;
        check("setwin pending end", bus_if.pending_o, 8'h00);
        check_out("setwin end", 1'b0, 3'd0);
        bus_if.out_ready_i = 1'b0;
        tick(2);

        // Mask: bit 7 held back while bit 0 is granted
        bus_if.mask_i = 8'h80;
        bus_if.req_i  = 8'h81; tick;
        bus_if.req_i  = 8'h00; tick(2);
        check("mask pending", bus_if.pending_o, 8'h81);
        tick; check_out("mask grant0", 1'b1, 3'd0);
        bus_if.out_ready_i = 1'b1;
        tick; check_out("mask blocked", 1'b0, 3'd0);
        check("mask pending7", bus_if.pending_o, 8'h80);
        bus_if.mask_i = 8'h00;
        tick; check_out("mask grant7", 1'b1, 3'd7);
        tick;
        check("mask pending end", bus_if.pending_o, 8'h00);
        bus_if.out_ready_i = 1'b0;
        tick(2);

        // Async reset mid-transfer with valid and ovf set
        bus_if.req_i = 8'h20; tick;
        bus_if.req_i = 8'h00; tick(3);
        check_out("pre-rst", 1'b1, 3'd5);
        bus_if.req_i = 8'h20; tick;
        bus_if.req_i = 8'h00; tick(2);
        check("pre-rst ovf", bus_if.ovf_o, 8'h20);
        #2 rst_n = 1'b0;
        #1;
        check("async valid", {7'd0, bus_if.out_valid_o}, 8'h00);
        check("async idx", {5'd0, bus_if.out_idx_o}, 8'h00);
        check("async pending", bus_if.pending_o, 8'h00);
        check("async ovf", bus_if.ovf_o, 8'h00);
        tick;
        rst_n = 1'b1;
        tick(2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
